// File: rtl/spi_slave_responder_if.sv
// Pin-side and stream-side signal bundle for spi_slave_responder.
// Defining SPI_DUAL_LANE_EN adds the second data lane (mosi1/miso1) and the cfg_dual select.
`timescale 1ns/1ps
interface spi_slave_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            cfg_mode;
    logic                  cfg_dir;
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi0;
    logic                  miso0;
    logic                  miso0_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  abort;
`ifdef SPI_DUAL_LANE_EN
    logic                  mosi1;
    logic                  miso1;
    logic                  cfg_dual;
`endif

    modport slave (
`ifdef SPI_DUAL_LANE_EN
        input  mosi1, cfg_dual,
        output miso1,
`endif
        input  cfg_mode, cfg_dir, sclk, cs_n, mosi0, tx_data, tx_valid,
        output miso0, miso0_oe, tx_ready, rx_data, rx_valid, tx_underrun, abort
    );

    modport master (
`ifdef SPI_DUAL_LANE_EN
        output mosi1, cfg_dual,
        input  miso1,
`endif
        output cfg_mode, cfg_dir, sclk, cs_n, mosi0, tx_data, tx_valid,
        input  miso0, miso0_oe, tx_ready, rx_data, rx_valid, tx_underrun, abort
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI responder: oversamples sclk/cs_n/mosi in the pclk domain, all four CPOL/CPHA modes, LSB/MSB first.
// Optional SPI_DUAL_LANE_EN macro enables two bits per sclk edge on mosi1/mosi0 and miso1/miso0.
`timescale 1ns/1ps
module spi_slave_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  areset,
    spi_slave_responder_if.slave  bus
);
    localparam int                CNT_W       = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_SINGLE = CNT_W'(DATA_WIDTH - 1);
`ifdef SPI_DUAL_LANE_EN
    localparam logic [CNT_W-1:0]  LAST_DUAL   = CNT_W'(DATA_WIDTH / 2 - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic msb, input logic two);
        logic [DATA_WIDTH-1:0] r;
        if (msb) begin
            r = two ? (w << 2'd2) : (w << 2'd1);
        end else begin
            r = two ? (w >> 2'd2) : (w >> 2'd1);
        end
        return r;
    endfunction

    // Bit on lane 0 that leaves next; in dual mode lane 0 carries the lower bit of the pair.
    function automatic logic head0(input logic [DATA_WIDTH-1:0] w, input logic msb, input logic two);
        logic r;
        if (msb) begin
            r = two ? w[DATA_WIDTH-2] : w[DATA_WIDTH-1];
        end else begin
            r = w[0];
        end
        return r;
    endfunction

`ifdef SPI_DUAL_LANE_EN
    function automatic logic head1(input logic [DATA_WIDTH-1:0] w, input logic msb);
        logic r;
        if (msb) begin
            r = w[DATA_WIDTH-1];
        end else begin
            r = w[1];
        end
        return r;
    endfunction
`endif

    function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] r,
                                                        input logic msb, input logic two,
                                                        input logic m1, input logic m0);
        logic [DATA_WIDTH-1:0] n;
        if (msb) begin
            n = two ? {r[DATA_WIDTH-3:0], m1, m0} : {r[DATA_WIDTH-2:0], m0};
        end else begin
            n = two ? {m1, m0, r[DATA_WIDTH-1:2]} : {m0, r[DATA_WIDTH-1:1]};
        end
        return n;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi0_sync_q;
    logic                   sclk_s, cs_s, mosi0_s, mosi1_s, dual_s;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_rise_s, sclk_fall_s, lead_s, trail_s, sample_s, shout_s, cs_fall_s;
    logic [CNT_W-1:0]       last_cnt_s;
    logic [DATA_WIDTH-1:0]  load_word_s, rx_next_s;

    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic                   dir_q, dir_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   abort_q, abort_d;
    logic                   miso0_q, miso0_d;
    logic                   oe_q, oe_d;

    // Input synchronisers; cs_n resets high so a freshly reset core sees an idle bus.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi0_sync_q <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi0_sync_q <= {mosi0_sync_q[SYNC_STAGES-2:0], bus.mosi0};
        end
    end

`ifdef SPI_DUAL_LANE_EN
    logic [SYNC_STAGES-1:0] mosi1_sync_q;
    logic                   dual_q, dual_d;
    logic                   miso1_q, miso1_d;

    // Second-lane synchroniser, dual-mode latch and lane-1 output register.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            mosi1_sync_q <= '0;
            dual_q       <= 1'b0;
            miso1_q      <= 1'b0;
        end else begin
            mosi1_sync_q <= {mosi1_sync_q[SYNC_STAGES-2:0], bus.mosi1};
            dual_q       <= dual_d;
            miso1_q      <= miso1_d;
        end
    end

    assign mosi1_s   = mosi1_sync_q[SYNC_STAGES-1];
    assign dual_s    = dual_q;
    assign bus.miso1 = miso1_q;
`else
    assign mosi1_s   = 1'b0;
    assign dual_s    = 1'b0;
`endif

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi0_s     = mosi0_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign lead_s      = mode_q[1] ? sclk_fall_s : sclk_rise_s;
    assign trail_s     = mode_q[1] ? sclk_rise_s : sclk_fall_s;
    assign sample_s    = mode_q[0] ? trail_s : lead_s;
    assign shout_s     = mode_q[0] ? lead_s : trail_s;
    assign cs_fall_s   = cs_prev_q & ~cs_s;
`ifdef SPI_DUAL_LANE_EN
    assign last_cnt_s  = dual_s ? LAST_DUAL : LAST_SINGLE;
`else
    assign last_cnt_s  = LAST_SINGLE;
`endif
    assign load_word_s = bus.tx_valid ? bus.tx_data : {DATA_WIDTH{1'b0}};
    assign rx_next_s   = rx_insert(rx_shift_q, dir_q, dual_s, mosi1_s, mosi0_s);

    // State and datapath registers.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q       <= ST_IDLE;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            mode_q        <= 2'b00;
            dir_q         <= 1'b0;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_ready_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            abort_q       <= 1'b0;
            miso0_q       <= 1'b0;
            oe_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            mode_q        <= mode_d;
            dir_q         <= dir_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            abort_q       <= abort_d;
            miso0_q       <= miso0_d;
            oe_q          <= oe_d;
        end
    end

    // Next-state and output logic; sclk edges only matter in SHIFT.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        dir_d         = dir_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_ready_d    = 1'b0;
        tx_underrun_d = 1'b0;
        abort_d       = 1'b0;
        miso0_d       = miso0_q;
        oe_d          = ~cs_s;
`ifdef SPI_DUAL_LANE_EN
        dual_d        = dual_q;
        miso1_d       = miso1_q;
`endif
        case (state_q)
            ST_IDLE: begin
                miso0_d   = 1'b0;
                bit_cnt_d = '0;
`ifdef SPI_DUAL_LANE_EN
                miso1_d   = 1'b0;
`endif
                if (cs_fall_s) begin
                    mode_d  = bus.cfg_mode;
                    dir_d   = bus.cfg_dir;
`ifdef SPI_DUAL_LANE_EN
                    dual_d  = bus.cfg_dual;
`endif
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cs_s) begin
                    miso0_d = 1'b0;
`ifdef SPI_DUAL_LANE_EN
                    miso1_d = 1'b0;
`endif
                    state_d = ST_IDLE;
                end else begin
                    tx_ready_d    = bus.tx_valid;
                    tx_underrun_d = ~bus.tx_valid;
                    rx_shift_d    = '0;
                    bit_cnt_d     = '0;
                    // CPHA=0 needs the first bit on the line before the first leading edge.
                    if (mode_q[0]) begin
                        tx_shift_d = load_word_s;
                    end else begin
                        miso0_d    = head0(load_word_s, dir_q, dual_s);
`ifdef SPI_DUAL_LANE_EN
                        miso1_d    = head1(load_word_s, dir_q);
`endif
                        tx_shift_d = shift_out(load_word_s, dir_q, dual_s);
                    end
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_s) begin
                    miso0_d   = 1'b0;
`ifdef SPI_DUAL_LANE_EN
                    miso1_d   = 1'b0;
`endif
                    abort_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (sample_s) begin
                    rx_shift_d = rx_next_s;
                    if (bit_cnt_q == last_cnt_s) begin
                        rx_data_d     = rx_next_s;
                        rx_valid_d    = 1'b1;
                        bit_cnt_d     = '0;
                        tx_shift_d    = load_word_s;
                        tx_ready_d    = bus.tx_valid;
                        tx_underrun_d = ~bus.tx_valid;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shout_s) begin
                    miso0_d    = head0(tx_shift_q, dir_q, dual_s);
`ifdef SPI_DUAL_LANE_EN
                    miso1_d    = head1(tx_shift_q, dir_q);
`endif
                    tx_shift_d = shift_out(tx_shift_q, dir_q, dual_s);
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.miso0       = miso0_q;
    assign bus.miso0_oe    = oe_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.abort       = abort_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder (simple SPI build, DATA_WIDTH=8), acting as SPI initiator.
`timescale 1ns/1ps
module tb_spi_slave_responder;
    localparam int W    = 8;
    localparam int HALF = 50;

    logic pclk   = 1'b0;
    logic areset = 1'b0;
    always #5 pclk = ~pclk;

    spi_slave_responder_if #(.DATA_WIDTH(W)) bus();

    spi_slave_responder #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .pclk   (pclk),
        .areset (areset),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int rx_cnt = 0, rdy_cnt = 0, unr_cnt = 0, abt_cnt = 0;
    int b_rx, b_rdy, b_unr, b_abt, b_log;
    logic [W-1:0] rx_log[$];
    logic [W-1:0] tx_q[$];
    logic [W-1:0] mosi_w[5];
    logic [W-1:0] tx_w[5];
    logic [W-1:0] miso_w[5];
    int           n_tx;
    logic         oe_mid;
    logic [5:0]   rst_flags;
    logic [W-1:0] rst_rx;

    // Pulse monitor: records every strobe the DUT raises outside reset.
    always @(negedge pclk) begin
        if (areset) begin
            if (bus.rx_valid === 1'b1) begin
                rx_cnt++;
                rx_log.push_back(bus.rx_data);
            end
            if (bus.tx_ready === 1'b1)    rdy_cnt++;
            if (bus.tx_underrun === 1'b1) unr_cnt++;
            if (bus.abort === 1'b1)       abt_cnt++;
        end
    end

    // Tx stream source: presents queued words, advancing after each tx_ready.
    always @(negedge pclk) begin
        if (bus.tx_valid !== 1'b1 || bus.tx_ready === 1'b1) begin
            if (tx_q.size() > 0) begin
                bus.tx_data  = tx_q.pop_front();
                bus.tx_valid = 1'b1;
            end else begin
                bus.tx_data  = '0;
                bus.tx_valid = 1'b0;
            end
        end
    end

    // Initiator: nwords full words then tail_bits of a partial word; optional reset mid-word.
    task automatic do_xfer(input logic [1:0] mode, input logic dir, input int nwords,
                           input int tail_bits, input bit rst_mid);
        int nb, idx;
        b_rx = rx_cnt; b_rdy = rdy_cnt; b_unr = unr_cnt; b_abt = abt_cnt; b_log = rx_log.size();
        for (int i = 0; i < n_tx; i++) tx_q.push_back(tx_w[i]);
        bus.cfg_mode = mode;
        bus.cfg_dir  = dir;
        bus.sclk     = mode[1];
        #100;
        bus.cs_n = 1'b0;
        #100;
        bus.cfg_mode = 2'($urandom_range(0, 3));
        bus.cfg_dir  = 1'($urandom_range(0, 1));
        oe_mid = bus.miso0_oe;
        for (int w = 0; w <= nwords; w++) begin
            nb = (w < nwords) ? W : tail_bits;
            miso_w[w] = '0;
            for (int i = 0; i < nb; i++) begin
                idx = dir ? (W - 1 - i) : i;
                if (!mode[0]) begin
                    bus.mosi0 = mosi_w[w][idx];
                    #HALF;
                    miso_w[w][idx] = bus.miso0;
                    bus.sclk = ~mode[1];
                    #HALF;
                    bus.sclk = mode[1];
                end else begin
                    #HALF;
                    bus.sclk  = ~mode[1];
                    bus.mosi0 = mosi_w[w][idx];
                    #HALF;
                    miso_w[w][idx] = bus.miso0;
                    bus.sclk = mode[1];
                end
            end
        end
        #HALF;
        if (rst_mid) begin
            areset = 1'b0;
            #1;
            rst_flags = {bus.miso0, bus.miso0_oe, bus.tx_ready, bus.rx_valid, bus.tx_underrun, bus.abort};
            rst_rx    = bus.rx_data;
            #9;
            bus.cs_n = 1'b1;
            #100;
            areset = 1'b1;
            #100;
        end else begin
            bus.cs_n = 1'b1;
            #300;
        end
    endtask

    task automatic test_reset();
        areset = 1'b0;
        #50;
        n_cmp++;
        if ({bus.miso0, bus.miso0_oe, bus.tx_ready, bus.rx_valid, bus.tx_underrun, bus.abort} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {bus.miso0, bus.miso0_oe, bus.tx_ready,
                     bus.rx_valid, bus.tx_underrun, bus.abort});
        end
        n_cmp++;
        if (bus.rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h want 00", bus.rx_data);
        end
        areset = 1'b1;
        #100;
        n_cmp++;
        if ({bus.miso0, bus.miso0_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_oe_miso: got %b want 00", {bus.miso0, bus.miso0_oe});
        end
    endtask

    task automatic test_mode0();
        mosi_w[0] = 8'hA5; tx_w[0] = 8'h3C; n_tx = 1;
        do_xfer(2'b00, 1'b1, 1, 0, 1'b0);
        n_cmp++;
        if (rx_cnt - b_rx !== 1 || rx_log[b_log] !== 8'hA5) begin
            n_fail++;
            $display("FAIL mode0_rx: got %0d words first %h want 1 word A5", rx_cnt - b_rx, rx_log[b_log]);
        end
        n_cmp++;
        if (miso_w[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL mode0_miso: got %h want 3c", miso_w[0]);
        end
        n_cmp++;
        if (rdy_cnt - b_rdy !== 1 || unr_cnt - b_unr !== 1 || abt_cnt - b_abt !== 0) begin
            n_fail++;
            $display("FAIL mode0_strobes: got rdy=%0d unr=%0d abt=%0d want 1 1 0",
                     rdy_cnt - b_rdy, unr_cnt - b_unr, abt_cnt - b_abt);
        end
        n_cmp++;
        if (oe_mid !== 1'b1 || bus.miso0_oe !== 1'b0 || bus.miso0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mode0_oe: got mid=%b end=%b miso=%b want 1 0 0", oe_mid, bus.miso0_oe, bus.miso0);
        end
    endtask

    task automatic test_modes_lsb();
        for (int m = 1; m < 4; m++) begin
            mosi_w[0] = 8'h81; tx_w[0] = 8'h5A; n_tx = 1;
            do_xfer(2'(m), 1'b0, 1, 0, 1'b0);
            n_cmp++;
            if (rx_cnt - b_rx !== 1 || rx_log[b_log] !== 8'h81) begin
                n_fail++;
                $display("FAIL mode%0d_lsb_rx: got %0d words first %h want 1 word 81", m, rx_cnt - b_rx,
                         rx_log[b_log]);
            end
            n_cmp++;
            if (miso_w[0] !== 8'h5A) begin
                n_fail++;
                $display("FAIL mode%0d_lsb_miso: got %h want 5a", m, miso_w[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        mosi_w[0] = 8'h12; mosi_w[1] = 8'h34;
        tx_w[0] = 8'($urandom); tx_w[1] = 8'($urandom); n_tx = 2;
        do_xfer(2'b01, 1'b1, 2, 0, 1'b0);
        n_cmp++;
        if (rx_cnt - b_rx !== 2 || rx_log[b_log] !== 8'h12 || rx_log[b_log+1] !== 8'h34) begin
            n_fail++;
            $display("FAIL b2b_rx: got %0d words %h %h want 2 words 12 34", rx_cnt - b_rx,
                     rx_log[b_log], rx_log[b_log+1]);
        end
        n_cmp++;
        if (miso_w[0] !== tx_w[0] || miso_w[1] !== tx_w[1]) begin
            n_fail++;
            $display("FAIL b2b_miso: got %h %h want %h %h", miso_w[0], miso_w[1], tx_w[0], tx_w[1]);
        end
        n_cmp++;
        if (rdy_cnt - b_rdy !== 2 || unr_cnt - b_unr !== 1) begin
            n_fail++;
            $display("FAIL b2b_strobes: got rdy=%0d unr=%0d want 2 1", rdy_cnt - b_rdy, unr_cnt - b_unr);
        end
    endtask

    task automatic test_underrun();
        mosi_w[0] = 8'($urandom); n_tx = 0;
        do_xfer(2'b11, 1'b1, 1, 0, 1'b0);
        n_cmp++;
        if (unr_cnt - b_unr !== 2 || rdy_cnt - b_rdy !== 0) begin
            n_fail++;
            $display("FAIL underrun_strobes: got unr=%0d rdy=%0d want 2 0", unr_cnt - b_unr, rdy_cnt - b_rdy);
        end
        n_cmp++;
        if (miso_w[0] !== 8'h00 || rx_log[b_log] !== mosi_w[0]) begin
            n_fail++;
            $display("FAIL underrun_data: got miso=%h rx=%h want 00 %h", miso_w[0], rx_log[b_log], mosi_w[0]);
        end
    endtask

    task automatic test_abort();
        mosi_w[0] = 8'($urandom); tx_w[0] = 8'($urandom); n_tx = 1;
        do_xfer(2'b00, 1'b1, 0, 5, 1'b0);
        n_cmp++;
        if (abt_cnt - b_abt !== 1 || rx_cnt - b_rx !== 0) begin
            n_fail++;
            $display("FAIL abort_pulse: got abt=%0d rx=%0d want 1 0", abt_cnt - b_abt, rx_cnt - b_rx);
        end
        mosi_w[0] = 8'hFF; tx_w[0] = 8'($urandom); n_tx = 1;
        do_xfer(2'b10, 1'b0, 1, 0, 1'b0);
        n_cmp++;
        if (rx_cnt - b_rx !== 1 || rx_log[b_log] !== 8'hFF || abt_cnt - b_abt !== 0) begin
            n_fail++;
            $display("FAIL after_abort_rx: got %0d words %h abt=%0d want 1 word ff abt=0", rx_cnt - b_rx,
                     rx_log[b_log], abt_cnt - b_abt);
        end
    endtask

    task automatic test_async_reset();
        mosi_w[0] = 8'($urandom); tx_w[0] = 8'($urandom); n_tx = 1;
        do_xfer(2'b01, 1'b1, 0, 4, 1'b1);
        n_cmp++;
        if (rst_flags !== 6'b0 || rst_rx !== 8'h00) begin
            n_fail++;
            $display("FAIL midword_reset: got flags=%b rx=%h want 000000 00", rst_flags, rst_rx);
        end
        mosi_w[0] = 8'h66; tx_w[0] = 8'($urandom); n_tx = 1;
        do_xfer(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1, 0, 1'b0);
        n_cmp++;
        if (rx_cnt - b_rx !== 1 || rx_log[b_log] !== 8'h66 || miso_w[0] !== tx_w[0]) begin
            n_fail++;
            $display("FAIL post_reset_xfer: got %0d words rx=%h miso=%h want 1 word 66 miso=%h",
                     rx_cnt - b_rx, rx_log[b_log], miso_w[0], tx_w[0]);
        end
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic       d;
        int         nw, tail, loads, exp_rdy;
        logic [W-1:0] exp_miso;
        for (int it = 0; it < 10; it++) begin
            m    = 2'($urandom_range(0, 3));
            d    = 1'($urandom_range(0, 1));
            nw   = $urandom_range(1, 3);
            tail = ($urandom_range(0, 1) == 1) ? $urandom_range(1, W - 1) : 0;
            for (int i = 0; i <= nw; i++) begin
                mosi_w[i] = 8'($urandom);
                tx_w[i]   = 8'($urandom);
            end
            n_tx = $urandom_range(0, nw + 1);
            do_xfer(m, d, nw, tail, 1'b0);
            loads   = nw + 1;
            exp_rdy = (n_tx < loads) ? n_tx : loads;
            n_cmp++;
            if (rx_cnt - b_rx !== nw) begin
                n_fail++;
                $display("FAIL rand%0d_rx_count: got %0d want %0d", it, rx_cnt - b_rx, nw);
            end
            for (int i = 0; i < nw; i++) begin
                exp_miso = (i < n_tx) ? tx_w[i] : 8'h00;
                n_cmp++;
                if (rx_log[b_log+i] !== mosi_w[i] || miso_w[i] !== exp_miso) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got rx=%h miso=%h want rx=%h miso=%h (mode %0d dir %0d)",
                             it, i, rx_log[b_log+i], miso_w[i], mosi_w[i], exp_miso, m, d);
                end
            end
            n_cmp++;
            if (rdy_cnt - b_rdy !== exp_rdy || unr_cnt - b_unr !== loads - exp_rdy ||
                abt_cnt - b_abt !== ((tail != 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand%0d_strobes: got rdy=%0d unr=%0d abt=%0d want %0d %0d %0d", it,
                         rdy_cnt - b_rdy, unr_cnt - b_unr, abt_cnt - b_abt, exp_rdy, loads - exp_rdy,
                         (tail != 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        bus.cs_n     = 1'b1;
        bus.sclk     = 1'b0;
        bus.mosi0    = 1'b0;
        bus.cfg_mode = 2'b00;
        bus.cfg_dir  = 1'b0;
`ifdef SPI_DUAL_LANE_EN
        bus.mosi1    = 1'b0;
        bus.cfg_dual = 1'b0;
`endif
        #100;
        test_reset();
        test_mode0();
        test_modes_lsb();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
